// File: rtl/share_add_seq.sv
// share_add_seq: sequencing front-end for the shared adder datapath.
// Takes one (a, b, c) operand triple per handshake. It then issues a+b (tag 0)
// followed by a+c (tag 1) through a single WIDTH+1-bit adder, and presents
// each registered result on a valid/ready output stream.
// Optional feature: define SHARE_ADD_SAT_EN to saturate out_data to all ones
// on carry-out. out_carry always reports the raw carry.
module share_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_tag,
  output logic             out_carry,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RES0 = 2'd1,
    RES1 = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_tag_q, out_tag_d;
  logic             out_carry_q, out_carry_d;

  // Shared adder signals
  logic             oper;
  logic [WIDTH-1:0] op_x;
  logic [WIDTH-1:0] b_src;
  logic [WIDTH-1:0] op_y;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_data;
  logic             res_carry;

  // Single shared adder. In IDLE it works on the live inputs, so the first
  // result can be registered on the accepting edge. Later cycles use the
  // captured operands. oper selects b (0) or c (1).
  always_comb begin
    oper      = (state_q == RES0);
    op_x      = (state_q == IDLE) ? in_a : a_q;
    b_src     = (state_q == IDLE) ? in_b : b_q;
    op_y      = oper ? c_q : b_src;
    sum       = {1'b0, op_x} + {1'b0, op_y};
    res_carry = sum[WIDTH];
`ifdef SHARE_ADD_SAT_EN
    res_data  = res_carry ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
    res_data  = sum[WIDTH-1:0];
`endif
  end

  // Next-state and result-register update. Every register holds by default,
  // which keeps the output stable under backpressure.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    out_carry_d = out_carry_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d     = RES0;
          a_d         = in_a;
          b_d         = in_b;
          c_d         = in_c;
          out_valid_d = 1'b1;
          out_data_d  = res_data;
          out_carry_d = res_carry;
          out_tag_d   = 1'b0;
        end
      end
      RES0: begin
        if (out_ready) begin
          state_d     = RES1;
          out_valid_d = 1'b1;
          out_data_d  = res_data;
          out_carry_d = res_carry;
          out_tag_d   = 1'b1;
        end
      end
      RES1: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State, operand and result registers. Reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= 1'b0;
      out_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      out_carry_q <= out_carry_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign out_carry = out_carry_q;

endmodule

// File: tb/tb_share_add_seq.sv
// Self-checking bench for share_add_seq. Expected results are queued when a
// triple is accepted, and they are compared when the DUT hands a result downstream.
module tb_share_add_seq;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [WIDTH-1:0] in_c = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_tag;
  logic             out_carry;
  logic             busy;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [9:0] exp_q[$];      // {carry, tag, data}
  bit         rec_en = 1'b0;
  int         xfer_cyc[$];

  share_add_seq #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_c     (in_c),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag),
    .out_carry(out_carry),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference sum: returns {carry, data}
  function automatic logic [8:0] ref_add(input logic [7:0] x, input logic [7:0] y);
    logic [8:0] s;
    s = {1'b0, x} + {1'b0, y};
`ifdef SHARE_ADD_SAT_EN
    if (s[8]) s[7:0] = 8'hFF;
`endif
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic t, input logic cy);
    exp_q.push_back({cy, t, d});
  endtask

  // Present a triple and hold it until accepted; queue the expected results
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input bit use_model, input logic [8:0] r0, input logic [8:0] r1);
    int n;
    logic [8:0] e0, e1;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_c = c;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check("accept_timeout", 32'(n >= 50), 32'd0);
    e0 = use_model ? ref_add(a, b) : r0;
    e1 = use_model ? ref_add(a, c) : r1;
    push_exp(e0[7:0], 1'b0, e0[8]);
    push_exp(e1[7:0], 1'b1, e1[8]);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: a result transfers at the next edge when valid & ready
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      logic [9:0] e;
      $display("[TB] result data=%02h tag=%0d carry=%0d", out_data, out_tag, out_carry);
      if (rec_en) xfer_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(e[7:0]));
        check("out_tag", 32'(out_tag), 32'(e[8]));
        check("out_carry", 32'(out_carry), 32'(e[9]));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb, rc;
    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_out_carry", 32'(out_carry), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Basic
    out_ready = 1'b1;
    send(8'h01, 8'h02, 8'h03, 1'b0, 9'h003, 9'h004);
    check("basic_busy", 32'(busy), 32'd1);
    step();
    step();
    check("basic_in_ready_back", 32'(in_ready), 32'd1);
    check("basic_q_empty", 32'(exp_q.size()), 32'd0);

    // Overflow
`ifdef SHARE_ADD_SAT_EN
    send(8'hF0, 8'h20, 8'h0F, 1'b0, 9'h1FF, 9'h0FF);
`else
    send(8'hF0, 8'h20, 8'h0F, 1'b0, 9'h110, 9'h0FF);
`endif
    drain();
    step();

    // Backpressure with operand change mid-stall
    out_ready = 1'b0;
    send(8'h01, 8'h02, 8'h03, 1'b0, 9'h003, 9'h004);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) in_a = 8'h7F;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'h03);
      check("bp_tag", 32'(out_tag), 32'd0);
      step();
    end
    out_ready = 1'b1;
    drain();
    step();

    // Busy ignore: a triple offered while in RES0 must not be captured
    out_ready = 1'b0;
    send(8'h05, 8'h06, 8'h07, 1'b1, 9'h0, 9'h0);
    in_valid = 1'b1;
    in_a = 8'h10;
    in_b = 8'h10;
    in_c = 8'h10;
    check("ign_in_ready", 32'(in_ready), 32'd0);
    step();
    in_valid = 1'b0;
    check("ign_data_held", 32'(out_data), 32'h0B);
    out_ready = 1'b1;
    drain();
    for (int i = 0; i < 3; i++) begin
      check("ign_no_extra", 32'(out_valid), 32'd0);
      step();
    end

    // Reset mid-op while in RES1
    send(8'h21, 8'h22, 8'h23, 1'b1, 9'h0, 9'h0);
    step();
    out_ready = 1'b0;
    check("mid_in_res1_tag", 32'(out_tag), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("mid_rel_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("mid_no_stale", 32'(out_valid), 32'd0);
      step();
    end

    // Back-to-back with in_valid held high
    rec_en = 1'b1;
    for (int t = 0; t < 3; t++) begin
      ra = 8'($urandom_range(255, 0));
      rb = 8'($urandom_range(255, 0));
      rc = 8'($urandom_range(255, 0));
      send(ra, rb, rc, 1'b1, 9'h0, 9'h0);
    end
    drain();
    step();
    rec_en = 1'b0;
    check("b2b_count", 32'(xfer_cyc.size()), 32'd6);
    if (xfer_cyc.size() == 6) begin
      for (int k = 1; k < 6; k++) begin
        check("b2b_gap", 32'(xfer_cyc[k] - xfer_cyc[k-1]), (k % 2 == 1) ? 32'd1 : 32'd2);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
